adt7420_i2c_target: RTL and testbench

//  I2C target (responder) modelling the ADT7420 temperature sensor that our

---
 rtl/adt7420_i2c_target.sv | 265 ++++++++++++++++++++++++++
 tb/tb_adt7420_i2c_target.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/adt7420_i2c_target.sv
// ---------------------------------------------------------------------------
// adt7420_i2c_target
//
// I2C target that behaves like an ADT7420 temperature sensor. It decodes
// START/STOP, answers to a single 7-bit address, keeps a register pointer
// that survives between transactions, ACKs address and write bytes, and
// returns register contents on reads with pointer auto-increment.
//
// Register map (reads): 0x00 temperature MSB, 0x01 temperature LSB,
// 0x02 status (always 0), 0x03 configuration, 0x0B device ID, others 0.
// Only 0x03 is writable; other writes are ACKed and dropped.
//
// Ports
//   Clock_100MHz    in   1   system clock, all logic on the rising edge
//   Clear_n         in   1   synchronous active-low reset
//   SCL_in          in   1   I2C clock from the master (asynchronous)
//   SDA_in          in   1   resolved SDA line (asynchronous)
//   SDA_drive_low   out  1   1 = pull SDA low, 0 = release
//   Temperature_in  in   16  live temperature {MSB,LSB}, 13-bit left-justified
//   Config_out      out  8   configuration register (0x03)
//   Pointer_out     out  8   current register pointer
// ---------------------------------------------------------------------------
module adt7420_i2c_target #(
  parameter logic [6:0] I2C_ADDRESS = 7'h4B,
  parameter logic [7:0] DEVICE_ID   = 8'hCB
) (
  input  logic        Clock_100MHz,
  input  logic        Clear_n,
  input  logic        SCL_in,
  input  logic        SDA_in,
  output logic        SDA_drive_low,
  input  logic [15:0] Temperature_in,
  output logic [7:0]  Config_out,
  output logic [7:0]  Pointer_out
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR,
    S_ADDR_ACK,
    S_PTR,
    S_PTR_ACK,
    S_WDATA,
    S_WDATA_ACK,
    S_RDATA,
    S_RDATA_ACK
  } state_t;

  // -------------------------------------------------------------------------
  // Input synchronisers and edge/condition detection. The idle bus is high,
  // so the flops reset to 1 to avoid a false edge when reset is released.
  // -------------------------------------------------------------------------
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic       scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others; blocking here would collapse the chain.
  always_ff @(posedge Clock_100MHz) begin
    if (!Clear_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], SCL_in};
      sda_sync <= {sda_sync[0], SDA_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  // SCL must be stable high on both samples so an SCL edge coinciding with
  // an SDA change is never mistaken for a bus condition.
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;      // bits shifted/driven in the current byte
  logic [7:0]  shift_q, shift_d;
  logic        drive_q, drive_d;
  logic [7:0]  ptr_q, ptr_d;
  logic [7:0]  config_q, config_d;
  logic [15:0] snap_q, snap_d;    // temperature captured at read-address ACK
  logic        rw_q, rw_d;

  logic [7:0]  rd_data;
  logic [7:0]  shift_in;

  always_ff @(posedge Clock_100MHz) begin
    if (!Clear_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      shift_q  <= 8'h00;
      drive_q  <= 1'b0;
      ptr_q    <= 8'h00;
      config_q <= 8'h00;
      snap_q   <= 16'h0000;
      rw_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      drive_q  <= drive_d;
      ptr_q    <= ptr_d;
      config_q <= config_d;
      snap_q   <= snap_d;
      rw_q     <= rw_d;
    end
  end

  // Register read mux. Temperature comes from the snapshot so a multi-byte
  // read of 0x00/0x01 is always taken from a single sample.
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_data = 8'h00;
    case (ptr_q)
      8'h00:   rd_data = snap_q[15:8];
      8'h01:   rd_data = snap_q[7:0];
      8'h03:   rd_data = config_q;
      8'h0B:   rd_data = DEVICE_ID;
      default: rd_data = 8'h00;
    endcase
  end

  assign shift_in = {shift_q[6:0], sda_s};

  // Next-state and datapath logic. Bytes are shifted on SCL rise; the ACK
  // slot (and every driven read bit) is entered on the following SCL fall,
  // so SDA_drive_low only ever changes on the clock after an SCL fall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    drive_d  = drive_q;
    ptr_d    = ptr_q;
    config_d = config_q;
    snap_d   = snap_q;
    rw_d     = rw_q;

    if (start_det) begin
      state_d = S_ADDR;
      cnt_d   = 4'd0;
      drive_d = 1'b0;
    end else if (stop_det) begin
      state_d = S_IDLE;
      cnt_d   = 4'd0;
      drive_d = 1'b0;
    end else begin
      case (state_q)
        S_ADDR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            cnt_d = 4'd0;
            if (shift_q[7:1] == I2C_ADDRESS) begin
              state_d = S_ADDR_ACK;
              drive_d = 1'b1;
              rw_d    = shift_q[0];
              if (shift_q[0]) snap_d = Temperature_in;
            end else begin
              // Not for us: stay off the bus until the next START.
              state_d = S_IDLE;
            end
          end
        end

        S_ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_q) begin
              // First read bit goes out on the same fall that ends the ACK.
              state_d = S_RDATA;
              shift_d = {rd_data[6:0], 1'b0};
              drive_d = ~rd_data[7];
              cnt_d   = 4'd1;
            end else begin
              state_d = S_PTR;
              drive_d = 1'b0;
            end
          end
        end

        S_PTR: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) ptr_d = shift_in;
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d = S_PTR_ACK;
            drive_d = 1'b1;
            cnt_d   = 4'd0;
          end
        end

        S_WDATA: begin
          if (scl_rise) begin
            shift_d = shift_in;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              if (ptr_q == 8'h03) config_d = shift_in;
              ptr_d = ptr_q + 8'd1;
            end
          end else if (scl_fall && cnt_q == 4'd8) begin
            state_d = S_WDATA_ACK;
            drive_d = 1'b1;
            cnt_d   = 4'd0;
          end
        end

        S_PTR_ACK, S_WDATA_ACK: begin
          if (scl_fall) begin
            state_d = S_WDATA;
            drive_d = 1'b0;
          end
        end

        S_RDATA: begin
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              // All eight bits out: release for the master's ACK/NACK.
              state_d = S_RDATA_ACK;
              drive_d = 1'b0;
              cnt_d   = 4'd0;
            end else begin
              drive_d = ~shift_q[7];
              shift_d = {shift_q[6:0], 1'b0};
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end

        S_RDATA_ACK: begin
          // cnt_q marks that an ACK was sampled and the next byte is due.
          if (scl_rise) begin
            ptr_d = ptr_q + 8'd1;
            if (sda_s) state_d = S_IDLE;
            else       cnt_d   = 4'd1;
          end else if (scl_fall && cnt_q == 4'd1) begin
            state_d = S_RDATA;
            shift_d = {rd_data[6:0], 1'b0};
            drive_d = ~rd_data[7];
            cnt_d   = 4'd1;
          end
        end

        default: ;
      endcase
    end
  end

  assign SDA_drive_low = drive_q;
  assign Config_out    = config_q;
  assign Pointer_out   = ptr_q;

endmodule

// File: tb/tb_adt7420_i2c_target.sv
// ---------------------------------------------------------------------------
// tb_adt7420_i2c_target
//
// Directed bench for adt7420_i2c_target. A bit-level I2C master drives SCL
// and an open-drain SDA; expected ACK bits and read bytes are queued when a
// byte is issued and popped when the bus returns the observed value.
// ---------------------------------------------------------------------------
module tb_adt7420_i2c_target;

  localparam int Q = 8;  // clocks per quarter SCL period

  logic        clk = 1'b0;
  logic        clear_n;
  logic        scl;
  logic        sda_m;
  logic        sda_line;
  logic        sda_drive_low;
  logic [15:0] temperature;
  logic [7:0]  config_out;
  logic [7:0]  pointer_out;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_q[$];
  string      tag_q[$];

  logic watch_bus = 1'b0;
  logic saw_drive = 1'b0;

  always #5 clk = ~clk;

  assign sda_line = sda_m & ~sda_drive_low;

  adt7420_i2c_target dut (
    .Clock_100MHz  (clk),
    .Clear_n       (clear_n),
    .SCL_in        (scl),
    .SDA_in        (sda_line),
    .SDA_drive_low (sda_drive_low),
    .Temperature_in(temperature),
    .Config_out    (config_out),
    .Pointer_out   (pointer_out)
  );

  always @(posedge clk) if (watch_bus && sda_drive_low) saw_drive <= 1'b1;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [7:0] exp);
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic sb_pop(input logic [7:0] obs);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard: observed %h with nothing expected", obs);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic clock_bit(input logic b, output logic sampled);
    sda_m = b;
    wait_q();
    scl = 1'b1;
    wait_q();
    sampled = sda_line;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    sda_m = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    sda_m = 1'b0;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    sda_m = 1'b1;
    wait_q();
  endtask

  // Send a byte and compare the ACK slot against the expected level.
  task automatic send_byte(input logic [7:0] data, input logic exp_ack, input string tag);
    logic s;
    sb_push(tag, {7'b0, exp_ack});
    for (int i = 7; i >= 0; i--) clock_bit(data[i], s);
    clock_bit(1'b1, s);
    sb_pop({7'b0, s});
  endtask

  // Read a byte with SDA released, then answer with master_ack.
  task automatic read_byte(input logic [7:0] exp, input logic master_ack, input string tag);
    logic       s;
    logic [7:0] v;
    v = 8'h00;
    sb_push(tag, exp);
    for (int i = 0; i < 8; i++) begin
      clock_bit(1'b1, s);
      v = {v[6:0], s};
    end
    sb_pop(v);
    clock_bit(master_ack, s);
  endtask

  initial begin
    clear_n     = 1'b0;
    scl         = 1'b1;
    sda_m       = 1'b1;
    temperature = 16'h0000;
    repeat (4) @(negedge clk);
    check("reset_drive", {7'b0, sda_drive_low}, 8'h00);
    check("reset_config", config_out, 8'h00);
    check("reset_pointer", pointer_out, 8'h00);
    clear_n = 1'b1;
    wait_q();

    // 1: pointer write to 0x0B, repeated START, read device ID, NACK.
    i2c_start();
    send_byte(8'h96, 1'b0, "t1_addr_w_ack");
    send_byte(8'h0B, 1'b0, "t1_ptr_ack");
    i2c_start();
    send_byte(8'h97, 1'b0, "t1_addr_r_ack");
    read_byte(8'hCB, 1'b1, "t1_device_id");
    check("t1_released_after_nack", {7'b0, sda_drive_low}, 8'h00);
    i2c_stop();
    check("t1_pointer", pointer_out, 8'h0C);

    // 2: two-byte temperature read stays coherent across a live change.
    temperature = 16'h1A38;
    i2c_start();
    send_byte(8'h96, 1'b0, "t2_addr_w_ack");
    send_byte(8'h00, 1'b0, "t2_ptr_ack");
    i2c_start();
    send_byte(8'h97, 1'b0, "t2_addr_r_ack");
    temperature = 16'h0000;
    read_byte(8'h1A, 1'b0, "t2_temp_msb");
    read_byte(8'h38, 1'b1, "t2_temp_lsb");
    i2c_stop();
    check("t2_pointer", pointer_out, 8'h02);

    // 3: configuration write.
    i2c_start();
    send_byte(8'h96, 1'b0, "t3_addr_w_ack");
    send_byte(8'h03, 1'b0, "t3_ptr_ack");
    send_byte(8'h80, 1'b0, "t3_data_ack");
    check("t3_config", config_out, 8'h80);
    i2c_stop();
    check("t3_pointer", pointer_out, 8'h04);

    // 4: foreign address; the target must stay off the bus entirely.
    saw_drive = 1'b0;
    watch_bus = 1'b1;
    i2c_start();
    send_byte(8'h90, 1'b1, "t4_addr_nack");
    send_byte(8'h00, 1'b1, "t4_byte2_nack");
    send_byte(8'h55, 1'b1, "t4_byte3_nack");
    i2c_stop();
    wait_q();
    watch_bus = 1'b0;
    check("t4_never_drove", {7'b0, saw_drive}, 8'h00);
    check("t4_pointer", pointer_out, 8'h04);
    check("t4_config", config_out, 8'h80);

    // 5: pointer wrap 0xFF -> 0x00 -> 0x01 during a two-byte read.
    i2c_start();
    send_byte(8'h96, 1'b0, "t5_addr_w_ack");
    send_byte(8'hFF, 1'b0, "t5_ptr_ack");
    i2c_start();
    send_byte(8'h97, 1'b0, "t5_addr_r_ack");
    read_byte(8'h00, 1'b0, "t5_reg_ff");
    read_byte(8'h00, 1'b1, "t5_reg_00");
    i2c_stop();
    check("t5_pointer_wrap", pointer_out, 8'h01);

    // 6: reset while the target is driving a 0 read bit (reg 0x01 = 0x38).
    temperature = 16'h1A38;
    i2c_start();
    send_byte(8'h97, 1'b0, "t6_addr_r_ack");
    check("t6_driving_zero", {7'b0, sda_drive_low}, 8'h01);
    @(negedge clk);
    clear_n = 1'b0;
    @(posedge clk);
    #1;
    check("t6_reset_drive", {7'b0, sda_drive_low}, 8'h00);
    check("t6_reset_config", config_out, 8'h00);
    check("t6_reset_pointer", pointer_out, 8'h00);
    repeat (3) @(negedge clk);
    clear_n = 1'b1;
    wait_q();
    i2c_start();
    send_byte(8'h96, 1'b0, "t6_addr_w_ack");
    send_byte(8'h03, 1'b0, "t6_ptr_ack");
    send_byte(8'h55, 1'b0, "t6_data_ack");
    i2c_stop();
    check("t6_config", config_out, 8'h55);
    check("t6_pointer", pointer_out, 8'h04);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
